offload_seq: RTL
================

# offload_seq

Multi-cycle sequencer for coprocessor and IO instructions in the single-cycle RISC-V core. It sits beside the main decoder and takes over whenever the decoded instruction is a coprocessor op or an IO access. While it runs, it stalls the PC and instruction fetch, runs a req/ack handshake with the coprocessor or the IO device, and writes the returned data to the register file in the cycle the stall releases. A timeout counter stops a hung device from locking the core.

## Interface
- DATA_W, 32, operand/result width
- TIMEOUT, 255, max wait cycles for ack before abort (>=1)

- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- cp_op  in  1  decoded instr is coprocessor op
- io_op  in  1  decoded instr is IO access
- io_write  in  1  IO access is a store (no writeback)
- funct3  in  3  sub-op, forwarded to coprocessor
- src_a, src_b  in  DATA_W  register operands (IO: src_a=addr, src_b=wdata)
- stall  out  1  freeze PC and fetch
- wb_en  out  1  one-cycle register-file write strobe
- wb_data  out  DATA_W  writeback value
- cp_req  out  1  coprocessor request
- cp_funct  out  3  latched funct3
- cp_a, cp_b  out  DATA_W  latched operands
- cp_ack  in  1  coprocessor done
- cp_rdata  in  DATA_W  coprocessor result
- io_req  out  1  IO request
- io_we  out  1  latched io_write
- io_addr, io_wdata  out  DATA_W  latched src_a/src_b
- io_ack  in  1  IO done
- io_rdata  in  DATA_W  IO read data
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

## Operation
- States: IDLE, CP_WAIT, IO_WAIT, WB.
- IDLE behaviour:
  - stall = cp_op | io_op, decoded combinationally so the PC holds in the decode cycle.
  - On cp_op: latch funct3/src_a/src_b and go to CP_WAIT. cp_op wins if both are asserted.
  - On io_op alone: latch operands and io_write, then go to IO_WAIT.
  - cp_ack/io_ack arriving in IDLE are ignored.
- *_WAIT behaviour:
  - stall=1. The matching req is registered high and holds until leaving the state. Latched outputs stay stable.
  - On ack: capture rdata into the result register, clear the counter, go to WB.
  - If there is no ack and the counter reaches TIMEOUT-1: set err, result=0, go to WB.
  - If ack and timeout land in the same cycle, ack wins and err is not set.
- WB behaviour:
  - stall=0, so the PC advances at the end of this cycle.
  - wb_en=1 unless the access was an IO store.
  - wb_data=result.
  - Next state is always IDLE. cp_op/io_op in WB belong to the completing instruction and are ignored.
- err is set by timeout and cleared by err_clr. If both happen in the same cycle, set wins.
- Counter is $clog2(TIMEOUT+1) bits wide. It counts only in *_WAIT, is zeroed on entry, and saturates (never wraps).

## Timing
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - cp_req=io_req=wb_en=err=0.
  - result and latched operands = 0, counter = 0.
  - stall is forced 0 while reset is low.
  - Reset mid-handshake drops req the next cycle. A late ack after reset is ignored.
- Latency:
  - decode cycle (stall), then N wait cycles (ack in the Nth), then WB.
  - Total stall = N+1 cycles; total instruction cycles = N+2.
  - Minimum is 3 cycles (ack in the first req cycle).
- wb_en is exactly one cycle wide and coincides with the PC update edge.
- Timeout path: req is high for exactly TIMEOUT cycles, then WB follows.
- Back-to-back offload instructions: the new instruction is seen in the IDLE cycle after WB and restarts with no bubble.

## Structure
- Package offload_pkg holds:
  - state_t enum (IDLE, CP_WAIT, IO_WAIT, WB);
  - the default DATA_W and TIMEOUT localparams.
- Sub-module offload_timer holds the saturating wait counter:
  - inputs: clr, en;
  - output: expired (count==TIMEOUT-1).
- The FSM, latches and result register stay in offload_seq.

## Test plan
- cp_op=1, funct3=3'b101, src_a=0x10, src_b=0x20, cp_ack on 1st req cycle with cp_rdata=0xCAFE:
  - cp_a=0x10, cp_b=0x20, cp_funct=5;
  - stall high 2 cycles;
  - wb_en with wb_data=0xCAFE in cycle 3.
- io_op=1, io_write=1, addr=0x8000, data=0x55, io_ack after 4 cycles:
  - io_we=1, io_req high 4 cycles;
  - WB has wb_en=0;
  - stall high 5 cycles.
- cp_op with no ack, TIMEOUT=8:
  - cp_req high exactly 8 cycles;
  - err=1, wb_en=1, wb_data=0;
  - err holds until err_clr.
- Ack in the same cycle the counter expires (TIMEOUT=8, ack on cycle 8):
  - result=rdata, err stays 0.
- reset=0 during IO_WAIT cycle 2:
  - next cycle io_req=0, stall=0, state IDLE;
  - an io_ack one cycle later causes no wb_en.
- Two consecutive cp_op instructions (acks after 1 and 2 cycles):
  - two distinct wb_en pulses with the correct data;
  - second decode starts the cycle right after the first WB.

Source files
------------

// File: rtl/offload_pkg.sv
// Shared state encoding and default sizing for the offload sequencer.
package offload_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CP_WAIT,
    IO_WAIT,
    WB
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/offload_seq_if.sv
// Decoder-side, coprocessor-side and IO-side signals of the offload sequencer.
interface offload_seq_if import offload_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cp_op;
  logic              io_op;
  logic              io_write;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              stall;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic              cp_req;
  logic [2:0]        cp_funct;
  logic [DATA_W-1:0] cp_a;
  logic [DATA_W-1:0] cp_b;
  logic              cp_ack;
  logic [DATA_W-1:0] cp_rdata;
  logic              io_req;
  logic              io_we;
  logic [DATA_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ack;
  logic [DATA_W-1:0] io_rdata;
  logic              err;
  logic              err_clr;

  modport master (
    input  cp_op, io_op, io_write, funct3, src_a, src_b,
    input  cp_ack, cp_rdata, io_ack, io_rdata, err_clr,
    output stall, wb_en, wb_data,
    output cp_req, cp_funct, cp_a, cp_b,
    output io_req, io_we, io_addr, io_wdata, err
  );

  modport slave (
    output cp_op, io_op, io_write, funct3, src_a, src_b,
    output cp_ack, cp_rdata, io_ack, io_rdata, err_clr,
    input  stall, wb_en, wb_data,
    input  cp_req, cp_funct, cp_a, cp_b,
    input  io_req, io_we, io_addr, io_wdata, err
  );

endinterface

// File: rtl/offload_timer.sv
// Saturating wait counter; expired_o marks the last cycle a device may still ack.
module offload_timer import offload_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/offload_seq.sv
// Multi-cycle sequencer that stalls the core while a coprocessor op or IO access
// completes its req/ack handshake, then writes the result back in the release cycle.
module offload_seq import offload_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  offload_seq_if.master bus
);

  state_t            state_q, state_d;
  logic [2:0]        funct_q, funct_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              in_wait;
  logic              expired;
  logic              timeout;

  assign in_wait = (state_q == CP_WAIT) || (state_q == IO_WAIT);

  offload_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (!in_wait),
    .en_i      (in_wait),
    .expired_o (expired)
  );

  // An ack in the expiry cycle still counts as success, so it is tested first.
  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    a_d      = a_q;
    b_d      = b_q;
    we_d     = we_q;
    result_d = result_q;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cp_op) begin
          funct_d = bus.funct3;
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          we_d    = 1'b0;
          state_d = CP_WAIT;
        end else if (bus.io_op) begin
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          we_d    = bus.io_write;
          state_d = IO_WAIT;
        end
      end
      CP_WAIT: begin
        if (bus.cp_ack) begin
          result_d = bus.cp_rdata;
          state_d  = WB;
        end else if (expired) begin
          result_d = '0;
          timeout  = 1'b1;
          state_d  = WB;
        end
      end
      IO_WAIT: begin
        if (bus.io_ack) begin
          result_d = bus.io_rdata;
          state_d  = WB;
        end else if (expired) begin
          result_d = '0;
          timeout  = 1'b1;
          state_d  = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = timeout | (err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      funct_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      we_q     <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      a_q      <= a_d;
      b_q      <= b_d;
      we_q     <= we_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // The decode cycle stalls combinationally so the PC holds before any state changes.
  assign bus.stall    = reset && ((state_q == IDLE) ? (bus.cp_op | bus.io_op) : in_wait);
  assign bus.cp_req   = (state_q == CP_WAIT);
  assign bus.io_req   = (state_q == IO_WAIT);
  assign bus.wb_en    = (state_q == WB) && !we_q;
  assign bus.wb_data  = result_q;
  assign bus.cp_funct = funct_q;
  assign bus.cp_a     = a_q;
  assign bus.cp_b     = b_q;
  assign bus.io_we    = we_q;
  assign bus.io_addr  = a_q;
  assign bus.io_wdata = b_q;
  assign bus.err      = err_q;

endmodule
